regfile_wb_arbiter: RTL and testbench
=====================================

Name: regfile_wb_arbiter

Overview:
- Shares the register file's single write port (A3/WD3/WE3) between two writeback requesters: req0 (ALU/execute result) and req1 (load/memory result).
- Arbitrates with valid/ready handshakes and drives the write port from registered outputs.
- Keeps a per-register pending-write scoreboard (busy mask) that hazard logic uses to stall dependent instructions.
- Counts committed writes for performance monitoring.

Parameters:
DATA_WIDTH, 32, width of writeback data and WD3
ADDR_WIDTH, 5, register index width; the register count is 2**ADDR_WIDTH
FIXED_PRIO, 0, 0 = round-robin arbitration; 1 = req0 always wins
CNT_WIDTH, 16, width of the saturating write counter

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous active-high reset
req0_valid  in  1  requester 0 has a writeback
req0_ready  out  1  requester 0 accepted this cycle (combinational)
req0_rd  in  ADDR_WIDTH  destination register, requester 0
req0_data  in  DATA_WIDTH  writeback value, requester 0
req1_valid  in  1  requester 1 has a writeback
req1_ready  out  1  requester 1 accepted this cycle (combinational)
req1_rd  in  ADDR_WIDTH  destination register, requester 1
req1_data  in  DATA_WIDTH  writeback value, requester 1
issue_valid  in  1  an instruction with a destination register issues this cycle
issue_rd  in  ADDR_WIDTH  destination of the issuing instruction
A3  out  ADDR_WIDTH  register file write address (registered)
WD3  out  DATA_WIDTH  register file write data (registered)
WE3  out  1  register file write enable (registered)
grant_id  out  1  requester that produced the current A3/WD3 (registered)
busy  out  2**ADDR_WIDTH  pending-write mask; bit i = register i has an outstanding producer
wr_count  out  CNT_WIDTH  saturating count of committed writes (WE3 cycles)

Behaviour:
- Reset (rst=1 at posedge):
  - Registered outputs: WE3=0, A3=0, WD3=0, grant_id=0, busy=0, wr_count=0.
  - Round-robin pointer is set so req0 wins the first contention.
  - Any transaction accepted in the reset cycle is discarded.
  - While rst=1, req0_ready and req1_ready are 0.
- Arbitration (combinational, every cycle, outside reset):
  - At most one requester is ready per cycle.
  - Only req0 valid -> req0_ready=1. Only req1 valid -> req1_ready=1. Neither valid -> both ready=0.
  - Both valid, FIXED_PRIO=1 -> req0 wins.
  - Both valid, FIXED_PRIO=0 -> the requester not granted at the most recent contention wins.
  - The round-robin pointer updates only on contention cycles; uncontended grants leave it unchanged.
  - ready never depends on the other requester's ready, so there is no combinational loop.
- Handshake:
  - Transfer occurs when valid && ready at a posedge.
  - The requester must hold rd/data stable while valid && !ready.
  - A losing requester stays stalled and retries in the next cycle.
- Write port (latency 1):
  - A transfer at edge N drives A3=rd, WD3=data, grant_id=winner, WE3=1 during cycle N+1.
  - A cycle with no transfer drives WE3=0 next cycle; A3/WD3/grant_id hold their last values.
  - A transfer with rd=0 is accepted (ready=1) but WE3 stays 0, so x0 is never written. It does not count in wr_count.
- Scoreboard:
  - issue_valid && issue_rd!=0 at an edge sets busy[issue_rd].
  - A committed write (WE3=1 in a cycle) clears busy[A3] at the end of that cycle.
  - Set and clear of the same bit in the same cycle: set wins, because a newer producer is in flight.
  - busy[0] is always 0.
  - Issuing to an already-busy register is legal; the bit stays 1 and the first writeback clears it. Hazard logic handles WAW by stalling issue.
- wr_count:
  - Increments once per cycle with WE3=1.
  - Saturates at 2**CNT_WIDTH-1 and never wraps.
  - Clears only on rst.
- Two requesters targeting the same rd in consecutive grants produce two writes in grant order; the later write's value is final.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, then all valids=0 for 5 cycles -> WE3=0, busy=0, wr_count=0, both ready=0.
- Single write: req0_valid=1, rd=5, data=0xDEADBEEF for 1 cycle -> req0_ready=1 that cycle; next cycle A3=5, WD3=0xDEADBEEF, WE3=1, grant_id=0; wr_count=1.
- Round-robin contention, FIXED_PRIO=0: both valid for 4 cycles (req0 rd=1 data=0x11, req1 rd=2 data=0x22) with each requester holding valid until accepted -> grants alternate 0,1,0,1; WE3 high 4 consecutive cycles; A3 sequence 1,2,1,2. With FIXED_PRIO=1 -> all 4 grants go to req0 and req1_ready=0 throughout.
- x0 drop: req1 valid with rd=0, data=0x1234 -> req1_ready=1; next cycle WE3=0; wr_count unchanged; busy[0]=0.
- Scoreboard: issue rd=7 -> busy[7]=1 next cycle. req0 write rd=7 -> busy[7]=0 after the WE3 cycle. Repeat with issue rd=7 in the same cycle WE3=1 and A3=7 -> busy[7] remains 1.
- Mid-operation reset and saturation: assert rst in the cycle a transfer is accepted -> next cycle WE3=0 and busy=0. With CNT_WIDTH=2, perform 5 writes -> wr_count=3.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | regfile_wb_arbiter                                                       |
// | Two-requester writeback arbiter for the register file write port, with   |
// | pending-write scoreboard and saturating committed-write counter.         |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module regfile_wb_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int FIXED_PRIO = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic [ADDR_WIDTH-1:0]    req0_rd,
  input  logic [DATA_WIDTH-1:0]    req0_data,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic [ADDR_WIDTH-1:0]    req1_rd,
  input  logic [DATA_WIDTH-1:0]    req1_data,
  input  logic                     issue_valid,
  input  logic [ADDR_WIDTH-1:0]    issue_rd,
  output logic [ADDR_WIDTH-1:0]    A3,
  output logic [DATA_WIDTH-1:0]    WD3,
  output logic                     WE3,
  output logic                     grant_id,
  output logic [2**ADDR_WIDTH-1:0] busy,
  output logic [CNT_WIDTH-1:0]     wr_count
);

  localparam int                   c_NREG    = 2**ADDR_WIDTH;
  localparam logic [CNT_WIDTH-1:0] c_CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] c_CNT_ONE = CNT_WIDTH'(1);

  // r_rr_ptr = 1 means req1 has priority at the next contention
  logic                  r_rr_ptr;
  logic                  w_contend;
  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_xfer;
  logic [ADDR_WIDTH-1:0] w_rd;
  logic [DATA_WIDTH-1:0] w_data;
  logic [c_NREG-1:0]     w_busy_nxt;

  // Each grant is derived from the valids and pointer only, never from the other ready
  always_comb begin
    w_contend = req0_valid && req1_valid;
    w_grant0  = !rst && req0_valid && (!req1_valid || (FIXED_PRIO != 0) || !r_rr_ptr);
    w_grant1  = !rst && req1_valid && (!req0_valid || ((FIXED_PRIO == 0) && r_rr_ptr));
    w_xfer    = w_grant0 || w_grant1;
    w_rd      = w_grant1 ? req1_rd   : req0_rd;
    w_data    = w_grant1 ? req1_data : req0_data;
  end

  assign req0_ready = w_grant0;
  assign req1_ready = w_grant1;

  // A newly issued producer wins over a same-cycle retiring write
  always_comb begin
    w_busy_nxt = busy;
    if (WE3) begin
      w_busy_nxt[A3] = 1'b0;
    end
    if (issue_valid && (issue_rd != '0)) begin
      w_busy_nxt[issue_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr <= 1'b0;
      A3       <= '0;
      WD3      <= '0;
      WE3      <= 1'b0;
      grant_id <= 1'b0;
      busy     <= '0;
      wr_count <= '0;
    end else begin
      if (w_contend) begin
        r_rr_ptr <= w_grant0;
      end
      if (w_xfer) begin
        A3       <= w_rd;
        WD3      <= w_data;
        grant_id <= w_grant1;
        WE3      <= (w_rd != '0);
      end else begin
        WE3      <= 1'b0;
      end
      busy <= w_busy_nxt;
      if (WE3 && (wr_count != c_CNT_MAX)) begin
        wr_count <= wr_count + c_CNT_ONE;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_regfile_wb_arbiter                                                    |
// | Directed vector bench for regfile_wb_arbiter (round-robin, fixed-prio,   |
// | narrow counter instances share one stimulus set).                       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_regfile_wb_arbiter;

  typedef struct {
    logic        rst;
    logic        v0;
    logic [4:0]  rd0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  rd1;
    logic [31:0] d1;
    logic        iv;
    logic [4:0]  ird;
    logic        er0;
    logic        er1;
    logic        ewe;
    logic        chk;
    logic [4:0]  ea3;
    logic [31:0] ewd;
    logic        eg;
    logic [31:0] ebusy;
    logic [15:0] ecnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid, issue_valid;
  logic [4:0]  req0_rd, req1_rd, issue_rd;
  logic [31:0] req0_data, req1_data;

  logic        r0, r1, we, gid;
  logic [4:0]  a3;
  logic [31:0] wd, busy;
  logic [15:0] cnt;

  logic        fp_r0, fp_r1, fp_we, fp_gid;
  logic [4:0]  fp_a3;
  logic [31:0] fp_wd, fp_busy;
  logic [15:0] fp_cnt;

  logic        c2_r0, c2_r1, c2_we, c2_gid;
  logic [4:0]  c2_a3;
  logic [31:0] c2_wd, c2_busy;
  logic [1:0]  c2_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(0), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(r0), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(r1), .req1_rd(req1_rd), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .A3(a3), .WD3(wd), .WE3(we), .grant_id(gid), .busy(busy), .wr_count(cnt)
  );

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(1), .CNT_WIDTH(16)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fp_r0), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(fp_r1), .req1_rd(req1_rd), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .A3(fp_a3), .WD3(fp_wd), .WE3(fp_we), .grant_id(fp_gid), .busy(fp_busy), .wr_count(fp_cnt)
  );

  regfile_wb_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .FIXED_PRIO(0), .CNT_WIDTH(2)) dut_c2 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(c2_r0), .req0_rd(req0_rd), .req0_data(req0_data),
    .req1_valid(req1_valid), .req1_ready(c2_r1), .req1_rd(req1_rd), .req1_data(req1_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd),
    .A3(c2_a3), .WD3(c2_wd), .WE3(c2_we), .grant_id(c2_gid), .busy(c2_busy), .wr_count(c2_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rs, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                       input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                       input logic iv, input logic [4:0] ird);
    rst = rs; req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    issue_valid = iv; issue_rd = ird;
  endtask

  function automatic vec_t mk(input logic rs, input logic v0, input logic [4:0] rd0, input logic [31:0] d0,
                              input logic v1, input logic [4:0] rd1, input logic [31:0] d1,
                              input logic iv, input logic [4:0] ird,
                              input logic er0, input logic er1, input logic ewe, input logic chk,
                              input logic [4:0] ea3, input logic [31:0] ewd, input logic eg,
                              input logic [31:0] ebusy, input logic [15:0] ecnt);
    vec_t v;
    v.rst = rs; v.v0 = v0; v.rd0 = rd0; v.d0 = d0; v.v1 = v1; v.rd1 = rd1; v.d1 = d1;
    v.iv = iv; v.ird = ird; v.er0 = er0; v.er1 = er1; v.ewe = ewe; v.chk = chk;
    v.ea3 = ea3; v.ewd = ewd; v.eg = eg; v.ebusy = ebusy; v.ecnt = ecnt;
    return v;
  endfunction

  vec_t vecs[27];

  initial begin
    //            rst v0 rd0 d0            v1 rd1 d1       iv ird  r0 r1 we chk a3 wd            g  busy    cnt
    vecs[0]  = mk(1, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  0, 0,            0, 0,      0);
    vecs[1]  = mk(1, 1, 3, 32'h55,       0, 0, 0,       1, 4,  0, 0, 0, 1,  0, 0,            0, 0,      0);
    vecs[2]  = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  0, 0,            0, 0,      0);
    vecs[3]  = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  0, 0,            0, 0,      0);
    vecs[4]  = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  0, 0,            0, 0,      0);
    vecs[5]  = mk(0, 1, 5, 32'hDEADBEEF, 0, 0, 0,       0, 0,  1, 0, 1, 1,  5, 32'hDEADBEEF, 0, 0,      0);
    vecs[6]  = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  5, 32'hDEADBEEF, 0, 0,      1);
    vecs[7]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  1, 0, 1, 1,  1, 32'h11,       0, 0,      1);
    vecs[8]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 1, 1, 1,  2, 32'h22,       1, 0,      2);
    vecs[9]  = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  1, 0, 1, 1,  1, 32'h11,       0, 0,      3);
    vecs[10] = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  0, 1, 1, 1,  2, 32'h22,       1, 0,      4);
    vecs[11] = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  2, 32'h22,       1, 0,      5);
    vecs[12] = mk(0, 0, 0, 0,            1, 0, 32'h1234, 0, 0, 0, 1, 0, 0,  0, 0,            0, 0,      5);
    vecs[13] = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 0,  0, 0,            0, 0,      5);
    vecs[14] = mk(0, 0, 0, 0,            0, 0, 0,       1, 7,  0, 0, 0, 0,  0, 0,            0, 32'h80, 5);
    vecs[15] = mk(0, 1, 7, 32'h77,       0, 0, 0,       0, 0,  1, 0, 1, 1,  7, 32'h77,       0, 32'h80, 5);
    vecs[16] = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  7, 32'h77,       0, 0,      6);
    vecs[17] = mk(0, 0, 0, 0,            0, 0, 0,       1, 7,  0, 0, 0, 1,  7, 32'h77,       0, 32'h80, 6);
    vecs[18] = mk(0, 1, 7, 32'h78,       0, 0, 0,       0, 0,  1, 0, 1, 1,  7, 32'h78,       0, 32'h80, 6);
    vecs[19] = mk(0, 0, 0, 0,            0, 0, 0,       1, 7,  0, 0, 0, 1,  7, 32'h78,       0, 32'h80, 7);
    vecs[20] = mk(0, 0, 0, 0,            0, 0, 0,       1, 0,  0, 0, 0, 1,  7, 32'h78,       0, 32'h80, 7);
    vecs[21] = mk(0, 0, 0, 0,            1, 7, 32'h79,  0, 0,  0, 1, 1, 1,  7, 32'h79,       1, 32'h80, 7);
    vecs[22] = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  7, 32'h79,       1, 0,      8);
    vecs[23] = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  1, 0, 1, 1,  1, 32'h11,       0, 0,      8);
    vecs[24] = mk(1, 1, 10, 32'hAA,      0, 0, 0,       1, 11, 0, 0, 0, 1,  0, 0,            0, 0,      0);
    vecs[25] = mk(0, 1, 1, 32'h11,       1, 2, 32'h22,  0, 0,  1, 0, 1, 1,  1, 32'h11,       0, 0,      0);
    vecs[26] = mk(0, 0, 0, 0,            0, 0, 0,       0, 0,  0, 0, 0, 1,  1, 32'h11,       0, 0,      1);

    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 27; i++) begin
      drive(vecs[i].rst, vecs[i].v0, vecs[i].rd0, vecs[i].d0, vecs[i].v1, vecs[i].rd1, vecs[i].d1,
            vecs[i].iv, vecs[i].ird);
      @(negedge clk);
      check($sformatf("v%0d req0_ready", i), 32'(r0), 32'(vecs[i].er0));
      check($sformatf("v%0d req1_ready", i), 32'(r1), 32'(vecs[i].er1));
      @(posedge clk);
      #1;
      check($sformatf("v%0d WE3", i), 32'(we), 32'(vecs[i].ewe));
      check($sformatf("v%0d busy", i), busy, vecs[i].ebusy);
      check($sformatf("v%0d wr_count", i), 32'(cnt), 32'(vecs[i].ecnt));
      if (vecs[i].chk) begin
        check($sformatf("v%0d A3", i), 32'(a3), 32'(vecs[i].ea3));
        check($sformatf("v%0d WD3", i), wd, vecs[i].ewd);
        check($sformatf("v%0d grant_id", i), 32'(gid), 32'(vecs[i].eg));
      end
    end

    // Fixed priority: req0 wins every contention, req1 starves
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 1, 32'h11, 1, 2, 32'h22, 0, 0);
      @(negedge clk);
      check($sformatf("fp%0d req0_ready", i), 32'(fp_r0), 32'd1);
      check($sformatf("fp%0d req1_ready", i), 32'(fp_r1), 32'd0);
      @(posedge clk); #1;
      check($sformatf("fp%0d WE3", i), 32'(fp_we), 32'd1);
      check($sformatf("fp%0d A3", i), 32'(fp_a3), 32'd1);
      check($sformatf("fp%0d grant_id", i), 32'(fp_gid), 32'd0);
    end

    // Saturation: five writes into a 2-bit counter stop at 3
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 3, 32'(i + 1), 0, 0, 0, 0, 0);
      @(posedge clk); #1;
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("sat c2 wr_count", 32'(c2_cnt), 32'd3);
    check("sat wide wr_count", 32'(cnt), 32'd5);
    check("sat last WD3", wd, 32'd5);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
